// File: rtl/layer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_ctrl_pkg
// Description : Shared encodings for the layer sequencer. Holds the top-level
//               mode encoding and the layer FSM state encoding. The top
//               controller and bus monitors import these as well.
// Contents    : mode_e          - top-level mode (IDLE / LOAD / LAYER)
//               layer_state_e   - layer FSM state (IDLE/LOAD/COMPUTE/DRAIN/FIN)
//               is_layer_start  - qualifies a start pulse against the mode
// Revision    : 1.0 - initial release
// ============================================================================
package layer_ctrl_pkg;

    localparam int c_MODE_W        = 3;
    localparam int c_LAYER_STATE_W = 3;

    typedef enum logic [c_MODE_W-1:0] {
        MODE_IDLE  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_LAYER = 3'd2
    } mode_e;

    typedef enum logic [c_LAYER_STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_FIN     = 3'd4
    } layer_state_e;

    // A start pulse only counts while the top controller is in LAYER mode.
    function automatic logic is_layer_start(input logic start_pulse,
                                            input logic [c_MODE_W-1:0] mode_val);
        return start_pulse && (mode_val == MODE_LAYER);
    endfunction

endpackage : layer_ctrl_pkg
`default_nettype wire

// File: rtl/layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : layer_ctrl
// Description : Layer sequencer below the top-level controller. On an accepted
//               start it walks the systolic array through NUM_LAYERS layers:
//               weight load (handshake), fixed compute window, output drain
//               (handshake). A watchdog aborts to idle and latches err when a
//               handshake stalls for TIMEOUT cycles.
// Ports       : clk             in  clock, rising edge
//               rst             in  synchronous active-high reset
//               mode[2:0]       in  top-level mode, LAYER (2) enables start
//               start_layering  in  1-cycle start pulse
//               wload_ack       in  weights for layer_idx are loaded
//               drain_done      in  1-cycle pulse, output drain complete
//               layer_ctrl_busy out high whenever the FSM is not idle
//               layer_idx       out layer being processed
//               wload_req       out level weight-load request
//               acc_clear       out 1-cycle accumulator clear
//               array_en        out compute enable, COMPUTE_CYCLES cycles
//               drain_start     out 1-cycle drain start
//               done            out 1-cycle run-complete pulse
//               err             out sticky watchdog timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module layer_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS     = 3,
    parameter int LAYER_W        = 2,
    parameter int COMPUTE_CYCLES = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT        = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mode,
    input  logic               start_layering,
    input  logic               wload_ack,
    input  logic               drain_done,
    output logic               layer_ctrl_busy,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               wload_req,
    output logic               acc_clear,
    output logic               array_en,
    output logic               drain_start,
    output logic               done,
    output logic               err
);

    localparam logic [CNT_W-1:0]   c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_COMPUTE_LAST = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE      = CNT_W'(1);
    localparam logic [LAYER_W-1:0] c_LAST_LAYER   = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [LAYER_W-1:0] c_LAYER_ONE    = LAYER_W'(1);

    layer_state_e       r_state;
    logic [CNT_W-1:0]   r_cnt;        // shared compute-window / watchdog counter
    logic [LAYER_W-1:0] r_layer_idx;
    logic               r_busy;
    logic               r_wload_req;
    logic               r_acc_clear;
    logic               r_array_en;
    logic               r_drain_start;
    logic               r_done;
    logic               r_err;

    logic               w_start_ok;
    logic               w_wdog_expired;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_start_ok     = is_layer_start(start_layering, mode);
    assign w_wdog_expired = (r_cnt == c_TIMEOUT_LAST);
    assign w_cnt_inc      = r_cnt + c_CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_layer_idx   <= '0;
            r_busy        <= 1'b0;
            r_wload_req   <= 1'b0;
            r_acc_clear   <= 1'b0;
            r_array_en    <= 1'b0;
            r_drain_start <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Pulse outputs default low; a transition below raises them for
            // exactly one cycle.
            r_acc_clear   <= 1'b0;
            r_drain_start <= 1'b0;
            r_done        <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_err       <= 1'b0;
                        r_layer_idx <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_wload_req <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Ack is checked first so an ack arriving on the last
                    // watchdog count still proceeds.
                    if (wload_ack) begin
                        r_wload_req <= 1'b0;
                        r_acc_clear <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_COMPUTE;
                    end else if (w_wdog_expired) begin
                        r_wload_req <= 1'b0;
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_COMPUTE: begin
                    // The first COMPUTE cycle carries acc_clear; the enable
                    // window starts after it so the clear lands before data.
                    if (r_acc_clear) begin
                        r_array_en <= 1'b1;
                        r_cnt      <= '0;
                    end else if (r_cnt == c_COMPUTE_LAST) begin
                        r_array_en    <= 1'b0;
                        r_drain_start <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_DRAIN;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_DRAIN: begin
                    if (drain_done) begin
                        r_cnt <= '0;
                        if (r_layer_idx == c_LAST_LAYER) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_layer_idx <= r_layer_idx + c_LAYER_ONE;
                            r_wload_req <= 1'b1;
                            r_state     <= S_LOAD;
                        end
                    end else if (w_wdog_expired) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_FIN: begin
                    // done is high this cycle with busy still asserted.
                    r_busy      <= 1'b0;
                    r_layer_idx <= '0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_wload_req <= 1'b0;
                    r_array_en  <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign layer_ctrl_busy = r_busy;
    assign layer_idx       = r_layer_idx;
    assign wload_req       = r_wload_req;
    assign acc_clear       = r_acc_clear;
    assign array_en        = r_array_en;
    assign drain_start     = r_drain_start;
    assign done            = r_done;
    assign err             = r_err;

endmodule : layer_ctrl
`default_nettype wire

// File: tb/tb_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_ctrl
// Description : Self-checking bench for layer_ctrl. Each scenario is turned
//               into a per-cycle table of inputs and expected outputs using
//               the run timeline (load wait, clear, compute window, drain
//               wait, done) worked out arithmetically from the handshake
//               delays chosen for each layer. The table is then played
//               against the DUT and every cycle's outputs are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_ctrl;

    localparam int c_NL = 3;
    localparam int c_LW = 2;
    localparam int c_CC = 8;
    localparam int c_CW = 8;
    localparam int c_TO = 200;

    localparam int P_IDLE  = 0;
    localparam int P_BAD   = 1;
    localparam int P_START = 2;
    localparam int P_LOAD  = 3;
    localparam int P_OTHER = 4;
    localparam int P_DRAIN = 5;

    // exp = {busy, layer_idx[1:0], wload_req, acc_clear, array_en,
    //        drain_start, done, err}
    typedef struct packed {
        bit         rst;
        bit         start;
        logic [2:0] mode;
        bit         ack;
        bit         ddn;
        logic [8:0] exp;
        int         scn;
    } step_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        mode;
    logic              start_layering;
    logic              wload_ack;
    logic              drain_done;
    logic              layer_ctrl_busy;
    logic [c_LW-1:0]   layer_idx;
    logic              wload_req;
    logic              acc_clear;
    logic              array_en;
    logic              drain_start;
    logic              done;
    logic              err;

    step_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    scn   = 0;
    bit    g_stray = 1'b0;
    bit    m_err   = 1'b0;
    int    m_layer = 0;

    always #5 clk = ~clk;

    layer_ctrl #(
        .NUM_LAYERS     (c_NL),
        .LAYER_W        (c_LW),
        .COMPUTE_CYCLES (c_CC),
        .CNT_W          (c_CW),
        .TIMEOUT        (c_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .start_layering  (start_layering),
        .wload_ack       (wload_ack),
        .drain_done      (drain_done),
        .layer_ctrl_busy (layer_ctrl_busy),
        .layer_idx       (layer_idx),
        .wload_req       (wload_req),
        .acc_clear       (acc_clear),
        .array_en        (array_en),
        .drain_start     (drain_start),
        .done            (done),
        .err             (err)
    );

    function automatic bit coin();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Append one cycle. The caller gives the expected outputs and the
    // handshake it owns for this phase; the other inputs get stray pulses
    // when g_stray is set (they must have no effect in this phase).
    task automatic push(input bit rs, input bit busy, input int layer,
                        input bit wreq, input bit acc, input bit aen,
                        input bit dst, input bit dn, input int ph,
                        input bit ack, input bit ddn);
        step_t s;
        logic [2:0] m;
        s.rst  = rs;
        s.scn  = scn;
        s.mode = 3'($urandom_range(0, 7));
        s.start = 1'b0;
        s.ack  = ack | (g_stray && ph != P_LOAD  && coin());
        s.ddn  = ddn | (g_stray && ph != P_DRAIN && coin());
        if (ph == P_BAD) begin
            s.start = 1'b1;
            s.mode  = 3'd1;
        end else if (ph == P_START) begin
            s.start = 1'b1;
            s.mode  = 3'd2;
        end else if (ph == P_IDLE) begin
            m = 3'($urandom_range(0, 7));
            if (m == 3'd2) m = 3'd3;
            s.mode  = m;
            s.start = g_stray && coin();
        end else begin
            s.start = g_stray && coin();
        end
        s.exp = {busy, c_LW'(layer), wreq, acc, aen, dst, dn, m_err};
        q.push_back(s);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b0, m_layer, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_IDLE, 1'b0, 1'b0);
    endtask

    task automatic add_bad_start();
        push(1'b0, 1'b0, m_layer, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_BAD, 1'b0, 1'b0);
    endtask

    // da: LOAD cycles before the ack (ack lands in LOAD cycle da, >= c_TO
    // means never). dd: same for drain_done in DRAIN. rst_layer: assert rst
    // in the third DRAIN cycle of that layer (-1 = never).
    task automatic add_run(input int da0, input int da1, input int da2,
                           input int dd0, input int dd1, input int dd2,
                           input int rst_layer);
        int da[c_NL];
        int dl[c_NL];
        bit rs;
        da = '{da0, da1, da2};
        dl = '{dd0, dd1, dd2};
        scn++;
        push(1'b0, 1'b0, m_layer, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_START, 1'b0, 1'b0);
        m_err = 1'b0;
        for (int l = 0; l < c_NL; l++) begin
            for (int i = 0; i < c_TO; i++) begin
                push(1'b0, 1'b1, l, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_LOAD, (i == da[l]), 1'b0);
                if (i == da[l]) break;
            end
            if (da[l] >= c_TO) begin
                m_err   = 1'b1;
                m_layer = l;
                return;
            end
            push(1'b0, 1'b1, l, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_OTHER, 1'b0, 1'b0);
            for (int j = 0; j < c_CC; j++)
                push(1'b0, 1'b1, l, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_OTHER, 1'b0, 1'b0);
            for (int i = 0; i < c_TO; i++) begin
                rs = (l == rst_layer) && (i == 2);
                push(rs, 1'b1, l, 1'b0, 1'b0, 1'b0, (i == 0), 1'b0, P_DRAIN, 1'b0,
                     (i == dl[l]) && !rs);
                if (rs) begin
                    m_err   = 1'b0;
                    m_layer = 0;
                    return;
                end
                if (i == dl[l]) break;
            end
            if (dl[l] >= c_TO) begin
                m_err   = 1'b1;
                m_layer = l;
                return;
            end
        end
        push(1'b0, 1'b1, c_NL - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_OTHER, 1'b0, 1'b0);
        m_layer = 0;
    endtask

    initial begin
        logic [8:0] obs;
        rst            = 1'b1;
        mode           = 3'd0;
        start_layering = 1'b0;
        wload_ack      = 1'b0;
        drain_done     = 1'b0;

        // Scenario table.
        add_idle(3);
        add_run(3, 1, 0, 0, 2, 1, -1);           // basic run, ack after 3 cycles
        add_idle(2);
        add_bad_start();                         // wrong mode: ignored
        add_idle(2);
        g_stray = 1'b1;
        add_idle(4);
        add_run(2, 4, 1, 3, 0, 5, -1);           // strays and starts while busy
        add_idle(3);
        g_stray = 1'b0;
        add_run(1, c_TO, 0, 1, 0, 0, -1);        // layer 1 ack withheld
        add_idle(5);
        add_run(0, 2, 3, 1, 1, 1, -1);           // restart clears err
        add_idle(2);
        add_run(1, 1, 1, 1, 6, 1, 1);            // reset in layer 1 drain
        add_idle(3);
        add_run(2, 2, 2, 2, 2, 2, -1);           // fresh run after reset
        add_idle(2);
        add_run(0, 0, c_TO - 1, 0, c_TO - 1, 0, -1);  // handshake on last count
        add_idle(2);
        add_run(1, 1, 1, c_TO, 0, 0, -1);        // drain watchdog on layer 0
        add_idle(2);
        g_stray = 1'b1;
        for (int r = 0; r < 4; r++) begin
            add_run($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), -1);
            add_idle($urandom_range(1, 3));
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; assert (layer_ctrl_busy === 1'b0) else begin bad++; $error("FAIL rst_busy observed=%b expected=0", layer_ctrl_busy); end
        total++; assert (layer_idx === 2'd0) else begin bad++; $error("FAIL rst_layer_idx observed=%0d expected=0", layer_idx); end
        total++; assert (wload_req === 1'b0) else begin bad++; $error("FAIL rst_wload_req observed=%b expected=0", wload_req); end
        total++; assert (acc_clear === 1'b0) else begin bad++; $error("FAIL rst_acc_clear observed=%b expected=0", acc_clear); end
        total++; assert (array_en === 1'b0) else begin bad++; $error("FAIL rst_array_en observed=%b expected=0", array_en); end
        total++; assert (drain_start === 1'b0) else begin bad++; $error("FAIL rst_drain_start observed=%b expected=0", drain_start); end
        total++; assert (done === 1'b0) else begin bad++; $error("FAIL rst_done observed=%b expected=0", done); end
        total++; assert (err === 1'b0) else begin bad++; $error("FAIL rst_err observed=%b expected=0", err); end

        // Play the table: drive just after the edge, check at the falling edge.
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk);
            #1;
            rst            = q[k].rst;
            start_layering = q[k].start;
            mode           = q[k].mode;
            wload_ack      = q[k].ack;
            drain_done     = q[k].ddn;
            @(negedge clk);
            obs = {layer_ctrl_busy, layer_idx, wload_req, acc_clear, array_en,
                   drain_start, done, err};
            total++;
            assert (obs === q[k].exp) else begin
                bad++;
                $error("FAIL outputs scn=%0d step=%0d observed=%b expected=%b (busy,idx[2],wreq,clr,en,dst,done,err)",
                       q[k].scn, k, obs, q[k].exp);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_layer_ctrl
`default_nettype wire
